// File: rtl/fft_sample_deserializer.sv
// rtl/fft_sample_deserializer.sv - serial complex samples into ping-pong frame banks for the FFT
// Frame is presented as a parallel val/rdy message; optional bit-reversed placement.
module fft_sample_deserializer #(
  parameter int BIT_WIDTH   = 32,
  parameter int N_SAMPLES   = 8,
  parameter int BIT_REVERSE = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [BIT_WIDTH-1:0]                recv_msg_real,
  input  logic [BIT_WIDTH-1:0]                recv_msg_imag,
  input  logic                                recv_val,
  output logic                                recv_rdy,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_real,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_imag,
  output logic                                send_val,
  input  logic                                send_rdy
);
  localparam int CW = $clog2(N_SAMPLES);

  logic [CW-1:0]                         r_cnt;
  logic                                  r_wr_bank;
  logic                                  r_rd_bank;
  logic [1:0]                            r_full;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]   r_real [2];
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]   r_imag [2];

  logic                                  w_recv_fire;
  logic                                  w_send_fire;
  logic                                  w_last;
  logic [CW-1:0]                         w_idx;
  logic [1:0]                            w_full_nxt;

  assign recv_rdy      = reset & ~r_full[r_wr_bank];
  assign send_val      = r_full[r_rd_bank];
  assign send_msg_real = r_real[r_rd_bank];
  assign send_msg_imag = r_imag[r_rd_bank];

  assign w_recv_fire = recv_val & recv_rdy;
  assign w_send_fire = send_val & send_rdy;
  assign w_last      = (r_cnt == CW'(N_SAMPLES - 1));

  always_comb begin
    w_idx = r_cnt;
    if (BIT_REVERSE != 0) begin
      for (int i = 0; i < CW; i++) w_idx[i] = r_cnt[CW-1-i];
    end
  end

  // Completion and release always target different banks, so both can apply.
  always_comb begin
    w_full_nxt = r_full;
    if (w_recv_fire && w_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_send_fire)           w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_full    <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
      if (w_recv_fire) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_wr_bank <= ~r_wr_bank;
      end
      if (w_send_fire) r_rd_bank <= ~r_rd_bank;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        r_real[b] <= '0;
        r_imag[b] <= '0;
      end
    end else if (w_recv_fire) begin
      r_real[r_wr_bank][w_idx] <= recv_msg_real;
      r_imag[r_wr_bank][w_idx] <= recv_msg_imag;
    end
  end

endmodule

// File: tb/tb_fft_sample_deserializer.sv
// tb/tb_fft_sample_deserializer.sv - self-checking bench, natural and bit-reversed instances
// A frame-queue model tracks pending frames; directed tables and sequences cover corners.
module tb_fft_sample_deserializer;
  localparam int W = 32;
  localparam int N = 8;

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct { vec_t re; vec_t im; } frame_t;
  typedef struct {
    logic         rv;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         sr;
    logic         e_rdy;
    logic         e_val;
    logic         chk;
  } row_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] recv_msg_real = '0;
  logic [W-1:0] recv_msg_imag = '0;
  logic         recv_val = 1'b0;
  logic         send_rdy = 1'b0;
  vec_t         nat_re, nat_im, rev_re, rev_im;
  logic         nat_rdy, rev_rdy, nat_val, rev_val;

  int n_checks = 0;
  int n_errors = 0;
  int rev_ord [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;

  fft_sample_deserializer #(.BIT_WIDTH(W), .N_SAMPLES(N), .BIT_REVERSE(0)) dut_nat (
    .clk(clk), .reset(reset),
    .recv_msg_real(recv_msg_real), .recv_msg_imag(recv_msg_imag),
    .recv_val(recv_val), .recv_rdy(nat_rdy),
    .send_msg_real(nat_re), .send_msg_imag(nat_im),
    .send_val(nat_val), .send_rdy(send_rdy)
  );

  fft_sample_deserializer #(.BIT_WIDTH(W), .N_SAMPLES(N), .BIT_REVERSE(1)) dut_rev (
    .clk(clk), .reset(reset),
    .recv_msg_real(recv_msg_real), .recv_msg_imag(recv_msg_imag),
    .recv_val(recv_val), .recv_rdy(rev_rdy),
    .send_msg_real(rev_re), .send_msg_imag(rev_im),
    .send_val(rev_val), .send_rdy(send_rdy)
  );

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string nm, input vec_t act, input vec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int base, input bit rv);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = W'(base + (rv ? rev_ord[i] : i));
    return v;
  endfunction

  // Reference: samples accumulate into a partial frame; completed frames wait in a
  // queue of at most two; input is ready whenever fewer than two frames are waiting.
  frame_t pend [$];
  frame_t part;
  int     pcnt = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend.delete();
      pcnt = 0;
    end else begin
      bit rf, sf;
      rf = recv_val && (pend.size() < 2);
      sf = send_rdy && (pend.size() > 0);
      if (sf) void'(pend.pop_front());
      if (rf) begin
        part.re[pcnt] = recv_msg_real;
        part.im[pcnt] = recv_msg_imag;
        pcnt++;
        if (pcnt == N) begin
          pend.push_back(part);
          pcnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic e_rdy, e_val;
    vec_t er_re, er_im;
    #2;
    e_rdy = reset && (pend.size() < 2);
    e_val = (pend.size() > 0);
    chk_bit("mon_rdy_nat", nat_rdy, e_rdy);
    chk_bit("mon_rdy_rev", rev_rdy, e_rdy);
    chk_bit("mon_val_nat", nat_val, e_val);
    chk_bit("mon_val_rev", rev_val, e_val);
    if (e_val) begin
      for (int i = 0; i < N; i++) begin
        er_re[i] = pend[0].re[rev_ord[i]];
        er_im[i] = pend[0].im[rev_ord[i]];
      end
      chk_vec("mon_re_nat", nat_re, pend[0].re);
      chk_vec("mon_im_nat", nat_im, pend[0].im);
      chk_vec("mon_re_rev", rev_re, er_re);
      chk_vec("mon_im_rev", rev_im, er_im);
    end else if (!reset) begin
      chk_vec("mon_re_rst", nat_re | rev_re, '0);
      chk_vec("mon_im_rst", nat_im | rev_im, '0);
    end
  end

  row_t tbl [10];
  vec_t x_nre, x_nim, x_rre, x_rim;
  int   acc, bad, frames;

  initial begin
    for (int k = 0; k < N; k++)
      tbl[k] = '{1'b1, W'(k), W'(100 + k), 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < N; i++) begin
      x_nre[i] = W'(i);
      x_nim[i] = W'(100 + i);
      x_rre[i] = W'(rev_ord[i]);
      x_rim[i] = W'(100 + rev_ord[i]);
    end

    // Reset held with recv_val high.
    recv_val = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_bit("rst_rdy_nat", nat_rdy, 1'b0);
    chk_bit("rst_rdy_rev", rev_rdy, 1'b0);
    chk_bit("rst_val", nat_val | rev_val, 1'b0);
    chk_vec("rst_msg", nat_re | nat_im | rev_re | rev_im, '0);
    @(negedge clk);
    recv_val = 1'b0;
    reset = 1'b1;
    #1;
    chk_bit("rel_rdy", nat_rdy & rev_rdy, 1'b1);

    // Natural and bit-reversed frame from table.
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      recv_val = tbl[r].rv;
      recv_msg_real = tbl[r].re;
      recv_msg_imag = tbl[r].im;
      send_rdy = tbl[r].sr;
      #1;
      chk_bit("tbl_rdy", nat_rdy, tbl[r].e_rdy);
      chk_bit("tbl_val", nat_val, tbl[r].e_val);
      if (tbl[r].chk) begin
        chk_vec("tbl_nat_re", nat_re, x_nre);
        chk_vec("tbl_nat_im", nat_im, x_nim);
        chk_vec("tbl_rev_re", rev_re, x_rre);
        chk_vec("tbl_rev_im", rev_im, x_rim);
      end
    end

    // Backpressure: only two frames fit.
    acc = 0;
    bad = 0;
    send_rdy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      recv_val = 1'b1;
      recv_msg_real = W'(1000 + acc);
      recv_msg_imag = W'(2000 + acc);
      #1;
      if (nat_val && (nat_re !== mk(1000, 0) || rev_re !== mk(1000, 1))) bad++;
      if (nat_rdy) acc++;
    end
    chk_int("bp_accepted", acc, 2 * N);
    chk_bit("bp_rdy_low", nat_rdy, 1'b0);
    chk_bit("bp_val", nat_val, 1'b1);
    chk_int("bp_stable", bad, 0);
    @(negedge clk);
    recv_val = 1'b0;
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
    #1;
    chk_bit("bp_next_val", nat_val, 1'b1);
    chk_vec("bp_next_re", nat_re, mk(1008, 0));
    chk_vec("bp_next_im_rev", rev_im, mk(2008, 1));
    chk_bit("bp_rdy_back", nat_rdy, 1'b1);
    @(negedge clk);
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
    #1;
    chk_bit("bp_drained", nat_val, 1'b0);

    // Simultaneous completion of frame B and release of frame A.
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      recv_val = (acc < 2 * N - 1);
      recv_msg_real = W'(3000 + acc);
      recv_msg_imag = W'(4000 + acc);
      #1;
      if (recv_val && nat_rdy) acc++;
    end
    chk_int("sim_prefill", acc, 2 * N - 1);
    @(negedge clk);
    recv_val = 1'b1;
    recv_msg_real = W'(3015);
    recv_msg_imag = W'(4015);
    send_rdy = 1'b1;
    #1;
    chk_bit("sim_pre_rdy", nat_rdy, 1'b1);
    chk_vec("sim_frame_a", nat_re, mk(3000, 0));
    @(negedge clk);
    recv_val = 1'b0;
    send_rdy = 1'b0;
    #1;
    chk_bit("sim_b_val", nat_val, 1'b1);
    chk_vec("sim_b_re", nat_re, mk(3008, 0));
    chk_vec("sim_b_im_rev", rev_im, mk(4008, 1));
    chk_bit("sim_a_freed", nat_rdy, 1'b1);
    @(negedge clk);
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
    #1;
    chk_bit("sim_drained", nat_val, 1'b0);

    // Reset in the middle of a frame discards the partial data.
    send_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      recv_val = 1'b1;
      recv_msg_real = W'(9000 + k);
      recv_msg_imag = W'(9100 + k);
    end
    @(negedge clk);
    recv_val = 1'b0;
    reset = 1'b0;
    #1;
    chk_bit("mid_rst_rdy", nat_rdy, 1'b0);
    chk_bit("mid_rst_val", nat_val, 1'b0);
    chk_vec("mid_rst_msg", nat_re | rev_im, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    frames = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      recv_val = (c < N);
      recv_msg_real = W'(500 + c);
      recv_msg_imag = W'(600 + c);
      #1;
      if (nat_val) begin
        frames++;
        chk_vec("mid_re", nat_re, mk(500, 0));
        chk_vec("mid_im", nat_im, mk(600, 0));
        chk_vec("mid_re_rev", rev_re, mk(500, 1));
      end
    end
    chk_int("mid_frames", frames, 1);

    // Random traffic against the frame-queue model.
    frames = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      recv_val = ($urandom_range(0, 3) != 0);
      send_rdy = ($urandom_range(0, 2) != 0);
      recv_msg_real = $urandom;
      recv_msg_imag = $urandom;
      #1;
      if (nat_val && send_rdy) frames++;
    end
    chk_bit("rand_progress", frames >= 100, 1'b1);
    @(negedge clk);
    recv_val = 1'b0;
    send_rdy = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk_bit("rand_drained", nat_val | rev_val, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_sample_deserializer.md
# fft_sample_deserializer

Serial-to-parallel front end for the FFT pipeline. It accepts one complex sample per handshake and assembles N_SAMPLES samples into a full frame. It then presents the frame as the parallel val/rdy vector message that the first FFT stage consumes. Samples are optionally placed in bit-reversed order. Two frame banks (ping-pong) let the next frame fill while the previous one waits for the FFT.

## Interface
- BIT_WIDTH, 32, width of each real/imag component.
- N_SAMPLES, 8, samples per frame. Power of two, ≥ 2.
- BIT_REVERSE, 1:
  - 1: serial sample k is stored at index bitrev(k) over log2(N_SAMPLES) bits.
  - 0: serial sample k is stored at index k.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low. Asserted when 0.
- recv_msg_real  in  BIT_WIDTH  serial sample, real part.
- recv_msg_imag  in  BIT_WIDTH  serial sample, imaginary part.
- recv_val  in  1  serial sample valid.
- recv_rdy  out  1  deserializer can accept a sample.
- send_msg_real  out  BIT_WIDTH × [N_SAMPLES-1:0]  frame, real parts.
- send_msg_imag  out  BIT_WIDTH × [N_SAMPLES-1:0]  frame, imaginary parts.
- send_val  out  1  a complete frame is presented.
- send_rdy  in  1  downstream FFT stage accepts the frame.

## Operation
- **Storage:** two banks B0 and B1, each holding N_SAMPLES real+imag words.
- **State registers:**
  - wr_bank (1 bit), rd_bank (1 bit).
  - cnt (log2 N_SAMPLES bits): sample index within the frame being filled.
  - full[1:0]: per-bank full flag.
- **Per-bank state machine:**
  - FILLING (full=0): bank owned by the writer.
  - FULL (full=1): bank owned by the reader.
  - FILLING→FULL when the N_SAMPLES-th sample is accepted into it.
  - FULL→FILLING when its frame is accepted downstream.
- **Input side:**
  - recv_rdy = reset deasserted AND !full[wr_bank].
  - Accept occurs when recv_val && recv_rdy. On accept:
    - Bank[wr_bank][idx] <= recv_msg, where idx = BIT_REVERSE ? bitrev(cnt) : cnt.
    - If cnt == N_SAMPLES-1: cnt <= 0, full[wr_bank] <= 1, wr_bank toggles.
    - Otherwise: cnt <= cnt + 1, wrapping naturally.
- **Output side:**
  - send_val = full[rd_bank].
  - send_msg_* = Bank[rd_bank], combinational from the registers.
  - Frame accept occurs when send_val && send_rdy. On frame accept: full[rd_bank] <= 0, rd_bank toggles.
  - send_msg_* holds stable while send_val=1 and send_rdy=0.
- **Simultaneous events:** input completion and output accept in the same cycle touch different banks, and both take effect. If wr_bank == rd_bank, that bank cannot be both completing and FULL in the same cycle.
- **Full condition:** both banks FULL ⇒ recv_rdy=0. Input stalls until a frame accept.
- **Empty condition:** both banks FILLING ⇒ send_val=0.
- **Data:** passes through unmodified; no arithmetic or width changes.
- **Reset (any time, including mid-frame):**
  - cnt=0, wr_bank=rd_bank=0, full=2'b00, bank contents=0.
  - Any partial frame, and any frame not yet accepted downstream, is discarded.

## Timing
- **Outputs while reset is asserted:** recv_rdy=0, send_val=0, send_msg_*=0.
- **First cycle after reset release:** recv_rdy=1.
- **Latency:** send_val rises on the clock edge that accepts the last sample of a frame, i.e. it is visible in the following cycle. The frame is accepted in the first cycle with send_val && send_rdy.
- **Throughput:** one sample per cycle, sustained, provided each frame is accepted within N_SAMPLES cycles of becoming valid.
- **Buffering:** with send_rdy held low, exactly 2·N_SAMPLES samples are accepted before recv_rdy drops.
- **Frame accept:** send_val drops (or moves to the other bank's frame) the cycle after the accept. If the other bank is FULL, send_val stays 1 and the next frame appears immediately.
- **No combinational paths:**
  - recv_val does not affect send_val in the same cycle.
  - send_rdy does not affect recv_rdy in the same cycle.

## Test plan
- **Reset:** assert reset=0 with recv_val=1 → recv_rdy=0, send_val=0, all send_msg_*=0. Release reset → recv_rdy=1 next cycle.
- **Natural order:** BIT_REVERSE=0, N=8, feed real=k, imag=100+k for k=0..7, send_rdy=1 → send_val=1 for one cycle with send_msg_real=[0..7] and send_msg_imag=[100..107].
- **Bit-reversed:** BIT_REVERSE=1, N=8, feed real=k for k=0..7 → send_msg_real[i] = 0,4,2,6,1,5,3,7 for i=0..7.
- **Backpressure/full:** send_rdy=0, recv_val=1 continuously:
  - Exactly 16 samples are accepted, then recv_rdy=0.
  - send_msg stays frame 0 and is stable.
  - Pulse send_rdy for 1 cycle → frame 1 is presented next cycle, and recv_rdy returns to 1.
- **Simultaneous:** with frame A FULL and frame B at cnt=7, accept B's last sample and A's send_rdy in the same cycle:
  - B becomes FULL and is presented next cycle.
  - A is released.
  - No sample is lost or duplicated.
- **Reset mid-frame:** after 5 samples are accepted, pulse reset low → send_val remains 0. A fresh 8 samples then produce exactly one frame containing only the post-reset data.
